// File: rtl/rng_uart_tx.sv
// rng_uart_tx: buffers 32-bit random words in a small FIFO and sends each one
// as four 8N1 UART bytes, most significant byte first. Words arriving while
// the FIFO is full are dropped, and a sticky flag plus a saturating count
// record the loss.
module rng_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] random_in,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and pointers
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, drop, pop;

  // Drop tracking
  logic       overflow_q;
  logic [7:0] drop_count_q;

  // Serializer state
  state_t      state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic [7:0]  cur_byte;

  // The full test uses the count from the start of the cycle, so a word that
  // arrives while the FIFO is full is dropped even if the FSM pops that cycle.
  assign full  = (count_q == FIFO_FULL);
  assign empty = (count_q == '0);
  assign push  = valid_in && !full;
  assign drop  = valid_in && full;

  assign cur_byte = shreg_q[31:24];

  // FIFO write, read and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= random_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  // Serializer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level for the state being entered so
  // the registered tx changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          byte_d  = '0;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shreg_d = {shreg_q[23:0], 8'h00};
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rng_uart_tx.sv
// tb_rng_uart_tx: directed checks of rng_uart_tx with a fast baud rate.
module tb_rng_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] random_in;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_errors = 0;

  rng_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .random_in (random_in),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] bw[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level k clocks after the pop edge; bytes = {b0,b1,b2,b3}.
  function automatic logic exp_tx(input logic [31:0] bytes, input int k);
    int slot;
    int j;
    int pos;
    logic [7:0] b;
    slot = k / CPB;
    j    = slot / 10;
    pos  = slot % 10;
    b    = bytes[31-8*j -: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Called right after the pop edge; checks all 40 bit times of one word.
  task automatic check_frame(input logic [31:0] bytes, input string name);
    int   bad_k;
    int   busy_bad;
    logic bad_v;
    bad_k    = -1;
    busy_bad = -1;
    bad_v    = 1'b0;
    for (int k = 0; k < 40*CPB; k++) begin
      if (tx !== exp_tx(bytes, k) && bad_k < 0) begin
        bad_k = k;
        bad_v = tx;
      end
      if (busy !== 1'b1 && busy_bad < 0) busy_bad = k;
      tick();
    end
    n_checks++;
    if (bad_k >= 0) begin
      n_errors++;
      $display("FAIL %s frame: cycle %0d tx=%b expected %b", name, bad_k, bad_v,
               exp_tx(bytes, bad_k));
    end
    n_checks++;
    if (busy_bad >= 0) begin
      n_errors++;
      $display("FAIL %s busy: low at cycle %0d expected 1", name, busy_bad);
    end
  endtask

  initial begin
    int   mono_bad;
    int   line_bad;
    logic [7:0] prev;

    vecs[0] = '{32'hA5C30F81, 8'hA5, 8'hC3, 8'h0F, 8'h81};
    vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
    vecs[4] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
    bw[0] = 32'hDEADBEEF; bw[1] = 32'h01234567; bw[2] = 32'h89ABCDEF;
    bw[3] = 32'h5A5A0FF0; bw[4] = 32'h13579BDF; bw[5] = 32'hCAFEF00D;

    rst = 1'b1; valid_in = 1'b0; random_in = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset overflow", overflow, 0);
    check("reset drop_count", drop_count, 0);
    tick();

    // Single words from the table: start bit two clocks after capture, busy 161 clocks.
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; random_in = vecs[i].word;
      tick();
      valid_in = 1'b0; random_in = '0;
      check($sformatf("vec%0d tx before pop", i), tx, 1);
      check($sformatf("vec%0d busy after push", i), busy, 1);
      tick();
      check_frame({vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3}, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tx idle", i), tx, 1);
      check($sformatf("vec%0d busy fall", i), busy, 0);
      check($sformatf("vec%0d overflow", i), overflow, 0);
      tick(); tick(); tick();
    end

    // Back-to-back alternating words; second push lands on the IDLE pop edge.
    valid_in = 1'b1; random_in = 32'hFFFFFFFF;
    tick();
    fork
      begin
        random_in = 32'h00000000; tick();
        random_in = 32'hFFFFFFFF; tick();
        valid_in = 1'b0; random_in = '0;
      end
      begin
        tick();
        check_frame(32'hFFFFFFFF, "b2b0");
        check("b2b gap0 tx", tx, 1);
        tick();
        check_frame(32'h00000000, "b2b1");
        check("b2b gap1 tx", tx, 1);
        tick();
        check_frame(32'hFFFFFFFF, "b2b2");
      end
    join
    check("b2b push/pop no drop", drop_count, 0);
    check("b2b overflow", overflow, 0);
    check("b2b busy end", busy, 0);
    tick();

    // Burst of six while idle: W0 popped at second edge, W1..W4 queued, W5 dropped.
    valid_in = 1'b1; random_in = bw[0];
    tick();
    fork
      begin
        for (int i = 1; i < 6; i++) begin
          random_in = bw[i]; tick();
        end
        valid_in = 1'b0; random_in = '0;
      end
      begin
        tick();
        for (int i = 0; i < 5; i++) begin
          check_frame(bw[i], $sformatf("burst w%0d", i));
          check($sformatf("burst gap%0d tx", i), tx, 1);
          if (i < 4) tick();
        end
      end
    join
    check("burst drop_count", drop_count, 1);
    check("burst overflow", overflow, 1);
    check("burst busy end", busy, 0);
    tick();

    // Saturation: valid held high for 300 cycles.
    mono_bad = 0;
    prev = drop_count;
    valid_in = 1'b1; random_in = 32'h00000077;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (drop_count < prev) mono_bad = 1;
      prev = drop_count;
    end
    valid_in = 1'b0;
    check("sat drop_count", drop_count, 255);
    check("sat no wrap", mono_bad, 0);
    check("sat overflow", overflow, 1);
    for (int i = 0; i < 20; i++) tick();
    check("sat drop_count hold", drop_count, 255);

    // Reset while a frame runs and the FIFO is full; valid during reset is ignored.
    rst = 1'b1; valid_in = 1'b1; random_in = 32'h11111111;
    tick();
    rst = 1'b0; valid_in = 1'b0; random_in = '0;
    check("rst1 tx", tx, 1);
    check("rst1 busy", busy, 0);
    check("rst1 overflow", overflow, 0);
    check("rst1 drop_count", drop_count, 0);
    for (int i = 0; i < 10; i++) tick();
    check("rst1 valid ignored", busy, 0);

    // Reset during DATA of byte index 2 with words queued.
    valid_in = 1'b1; random_in = bw[0];
    tick();
    for (int i = 1; i < 6; i++) begin
      random_in = bw[i]; tick();
    end
    valid_in = 1'b0; random_in = '0;
    for (int i = 0; i < 86; i++) tick();
    check("pre-rst tx", tx, exp_tx(bw[0], 90));
    check("pre-rst overflow", overflow, 1);
    check("pre-rst drop_count", drop_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2 tx", tx, 1);
    check("rst2 busy", busy, 0);
    check("rst2 overflow", overflow, 0);
    check("rst2 drop_count", drop_count, 0);
    line_bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) line_bad++;
    end
    check("rst2 line quiet", line_bad, 0);

    // Recovery: a fresh word after reset is sent normally.
    valid_in = 1'b1; random_in = 32'h3C96E187;
    tick();
    valid_in = 1'b0; random_in = '0;
    tick();
    check_frame({8'h3C, 8'h96, 8'hE1, 8'h87}, "post-rst");
    check("post-rst busy end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rng_uart_tx.md
# rng_uart_tx

Output-side consumer for the TRNG post-processing stage. It accepts whitening-stage output words (`valid_in` pulse with a 32-bit `random_in`) and buffers them in a small word FIFO. It serializes each word as four 8N1 UART bytes on `tx` for capture by a host PC. The producer has no backpressure, so words arriving while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clocks per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 4: word capacity of the FIFO. Must be a power of 2 and ≥ 2.

Ports:
- `clk`  input  1: single clock. All logic is on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `valid_in`  input  1: one-cycle qualifier for `random_in`.
- `random_in`  input  32: post-processed random word.
- `tx`  output  1: UART serial line. Idles high.
- `busy`  output  1: high when the FSM is not IDLE or the FIFO is non-empty.
- `overflow`  output  1: sticky flag. Set on the first dropped word; cleared only by `rst`.
- `drop_count`  output  8: number of dropped words. Saturates at 255.

## Operation
- **FIFO push.** A push occurs when `valid_in`=1 and the FIFO is not full at the start of the cycle.
  - A push and a pop in the same cycle are both allowed when the FIFO is not full; the count is unchanged.
  - If `valid_in`=1 while the FIFO is full, the word is dropped, even if a pop occurs that cycle. On a drop, `overflow` is set to 1 and `drop_count` increments, saturating at 255.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** if the FIFO is non-empty, pop the head word into the 32-bit shift register, set byte index = 0, and go to START. Otherwise stay in IDLE with `tx`=1.
  - **START:** `tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA with bit index = 0.
  - **DATA:** `tx` = the current byte, sent LSB first. Each bit is held `CLKS_PER_BIT` clocks. After bit 7, go to STOP.
  - **STOP:** `tx`=1 for `CLKS_PER_BIT` clocks. Then:
    - if byte index < 3: increment the byte index and go to START;
    - otherwise go to IDLE.
- **Byte order within a word:** `[31:24]` first, then `[23:16]`, `[15:8]`, `[7:0]`.
- **Baud counter:** counts 0..`CLKS_PER_BIT`−1 and resets at every state or bit boundary. Its width is `$clog2(CLKS_PER_BIT)`.
- **Registered outputs:** `tx` is a registered output with no combinational path from inputs.
- **Reset:** all outputs take their reset values on the next edge, and any in-progress frame is aborted. Reset values:
  - `tx`=1, `busy`=0, `overflow`=0, `drop_count`=0
  - FIFO empty, FSM in IDLE
  - `valid_in` is ignored during the reset cycle.

## Timing
- **First start bit.** Let `valid_in` be sampled at edge N, with the FIFO empty and the FSM in IDLE.
  - The FIFO count is 1 after edge N.
  - The IDLE pop happens at edge N+1.
  - `tx` goes low after edge N+1 (two clocks after capture).
- **Frame length.** One word is 40 × `CLKS_PER_BIT` clocks, measured from the fall of the first start bit to the end of the fourth stop bit.
- **Gap between words.**
  - Between bytes of one word: no gap. STOP goes directly to the next START.
  - Between words: after the fourth stop bit, the FSM spends exactly 1 clock in IDLE (`tx`=1). The next start bit follows if the FIFO is non-empty.
- **`busy` timing.** `busy` rises the cycle after the first push. It falls the cycle after the FSM enters IDLE with the FIFO empty.
- **Throughput.** Sustained throughput is one word per 40 × `CLKS_PER_BIT` + 1 clocks. Producer bursts faster than this are absorbed up to `FIFO_DEPTH` words and dropped beyond that.

## Test plan
- **Single word.** `CLKS_PER_BIT`=4; one `valid_in` with `random_in`=0xA5C30F81.
  - Expect `tx` to decode to bytes A5, C3, 0F, 81.
  - Each bit must be exactly 4 clocks; the start bit falls 2 clocks after capture.
  - Expect `busy` to be high for 161 clocks; `overflow` stays 0.
- **Burst overflow.** `FIFO_DEPTH`=4; six consecutive `valid_in` cycles with words W0..W5 while idle.
  - W0 is popped at the second edge; W1..W4 are queued; W5 is dropped.
  - Expect `drop_count`=1 and `overflow`=1.
  - Output is W0..W4, with exactly 1 idle clock between words.
- **Drop saturation.** Hold `valid_in`=1 for 300 cycles with `CLKS_PER_BIT`=868.
  - Expect `drop_count`=255 thereafter, no wrap, and `overflow` held at 1.
- **Simultaneous push/pop at count 1.** Push at the exact cycle of an IDLE pop.
  - Expect the word to be accepted, count unchanged, and no drop.
- **Reset mid-frame.** Assert `rst` during DATA of byte 2, with words queued.
  - Expect `tx`=1 on the next edge, FIFO empty, and `busy`=0, `overflow`=0, `drop_count`=0.
  - No further frames until a new `valid_in`.
- **Back-to-back line timing.** Alternate words 0xFFFFFFFF and 0x00000000.
  - Check start/stop framing and that the inter-word idle is exactly one clock plus the stop bit.
